fpaddsub_norm_shift: RTL and testbench



---
 rtl/fpaddsub_pkg.sv | 27 ++
 rtl/fpaddsub_lzc25.sv | 19 +
 rtl/fpaddsub_norm_shift.sv | 129 ++++++++++++
 tb/tb_fpaddsub_norm_shift.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpaddsub_pkg.sv
// Shared types and constants for the FP add/sub post-addition normalizer.
package fpaddsub_pkg;

  localparam int EXP_W   = 8;
  localparam int SUM_W   = 26;
  localparam int FRAC_W  = 23;
  localparam int LZ_W    = 5;
  localparam int EXP_MAX = 255;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
    logic              grd;
    logic              stk;
  } norm_res_t;

  typedef struct packed {
    logic [SUM_W-1:0] sum;
    logic [EXP_W-1:0] exp;
    logic             sign;
    logic             stk;
    logic             ovf;
    logic [LZ_W-1:0]  lz;
  } s1_reg_t;

endpackage

// File: rtl/fpaddsub_lzc25.sv
// Combinational 25-bit leading-nought counter; all-zero input returns 25.
module fpaddsub_lzc25
  import fpaddsub_pkg::*;
(
  input  logic [24:0]     d_i,
  output logic [LZ_W-1:0] lz_o
);

  // Ascending scan so the highest set bit writes last and wins.
  always_comb begin
    lz_o = 5'd25;
    for (int i = 0; i < 25; i++) begin
      if (d_i[i]) begin
        lz_o = 5'(24 - i);
      end
    end
  end

endmodule

// File: rtl/fpaddsub_norm_shift.sv
// Two-stage elastic normalizer: S1 counts leading noughts, S2 shifts the
// significand, adjusts the exponent and holds the result for the rounder.
module fpaddsub_norm_shift
  import fpaddsub_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [25:0] in_sum,
  input  logic [7:0]  in_exp,
  input  logic        in_sign,
  input  logic        in_stk,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sign,
  output logic [7:0]  out_exp,
  output logic [22:0] out_frac,
  output logic        out_grd,
  output logic        out_stk
);

  localparam logic [8:0] EXP_MAX9 = 9'(EXP_MAX);

  logic            s1_valid_q, s1_valid_d;
  logic            s2_valid_q, s2_valid_d;
  s1_reg_t         s1_q, s1_d;
  norm_res_t       res_q, res_d;
  norm_res_t       norm_s;
  logic [LZ_W-1:0] lz_s;
  logic            in_fire_s;
  logic            s2_load_s;
  logic [8:0]      exp_inc_s;
  logic [7:0]      exp_sub_s;
  logic [23:0]     m_s;

  fpaddsub_lzc25 u_lzc (
    .d_i  (in_sum[24:0]),
    .lz_o (lz_s)
  );

  assign s2_load_s = s1_valid_q & (~s2_valid_q | out_ready);
  assign in_ready  = ~s1_valid_q | s2_load_s;
  assign in_fire_s = in_valid & in_ready;

  // S1 capture: raw operands plus carry flag and leading-nought count.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (in_fire_s) begin
      s1_valid_d = 1'b1;
      s1_d.sum   = in_sum;
      s1_d.exp   = in_exp;
      s1_d.sign  = in_sign;
      s1_d.stk   = in_stk;
      s1_d.ovf   = in_sum[25];
      s1_d.lz    = lz_s;
    end else if (s2_load_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // The hidden bit is discarded, so only the 24 bits below it are formed.
  always_comb begin
    exp_inc_s   = {1'b0, s1_q.exp} + 9'd1;
    exp_sub_s   = s1_q.exp - {3'd0, s1_q.lz};
    m_s         = s1_q.ovf ? s1_q.sum[24:1] : (s1_q.sum[23:0] << s1_q.lz);
    norm_s      = '0;
    norm_s.sign = s1_q.sign;
    if (s1_q.ovf) begin
      if (exp_inc_s >= EXP_MAX9) begin
        norm_s.exp = 8'(EXP_MAX);
      end else begin
        norm_s.exp  = exp_inc_s[7:0];
        norm_s.frac = m_s[23:1];
        norm_s.grd  = m_s[0];
        norm_s.stk  = s1_q.stk | s1_q.sum[0];
      end
    end else if (s1_q.sum[24:0] == 25'd0) begin
      norm_s.sign = 1'b0;
    end else if ({3'd0, s1_q.lz} >= s1_q.exp) begin
      norm_s.exp = 8'd0;
    end else begin
      norm_s.exp  = exp_sub_s;
      norm_s.frac = m_s[23:1];
      norm_s.grd  = m_s[0];
      norm_s.stk  = s1_q.stk;
    end
  end

  // S2 next state: load a fresh result or retire the held one.
  always_comb begin
    s2_valid_d = s2_valid_q;
    res_d      = res_q;
    if (s2_load_s) begin
      s2_valid_d = 1'b1;
      res_d      = norm_s;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Pipeline registers; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      res_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      res_q      <= res_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_sign  = res_q.sign;
  assign out_exp   = res_q.exp;
  assign out_frac  = res_q.frac;
  assign out_grd   = res_q.grd;
  assign out_stk   = res_q.stk;

endmodule

// File: tb/tb_fpaddsub_norm_shift.sv
// Self-checking bench: directed vector table, handshake corner sequences and
// a randomized stream scored against a behavioural normalization model.
module tb_fpaddsub_norm_shift;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
    logic        grd;
    logic        stk;
  } exp_t;

  typedef struct {
    logic [25:0] sum;
    logic [7:0]  exp;
    logic        sign;
    logic        stk;
    exp_t        res;
    string       nm;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [25:0] in_sum;
  logic [7:0]  in_exp;
  logic        in_sign;
  logic        in_stk;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [22:0] out_frac;
  logic        out_grd;
  logic        out_stk;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb[$];

  fpaddsub_norm_shift dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_exp    (in_exp),
    .in_sign   (in_sign),
    .in_stk    (in_stk),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_frac  (out_frac),
    .out_grd   (out_grd),
    .out_stk   (out_stk)
  );

  always #5 clk = ~clk;

  function automatic exp_t cur_out();
    return {out_sign, out_exp, out_frac, out_grd, out_stk};
  endfunction

  // Reference: locate the leading one arithmetically and scale by a power of two.
  function automatic exp_t model(input logic [25:0] s, input logic [7:0] e,
                                 input logic sg, input logic st);
    exp_t        r;
    int          p;
    int          lz;
    logic [63:0] v;
    r      = '0;
    r.sign = sg;
    if (s >= 26'h2000000) begin
      if (int'(e) + 1 >= 255) begin
        r.exp = 8'd255;
      end else begin
        r.exp  = 8'(int'(e) + 1);
        r.frac = s[24:2];
        r.grd  = s[1];
        r.stk  = st | s[0];
      end
    end else if (s == 26'd0) begin
      r.sign = 1'b0;
    end else begin
      p = 24;
      while (s[p] == 1'b0) p--;
      lz = 24 - p;
      if (lz < int'(e)) begin
        v      = 64'(s) * 64'(2 ** lz);
        r.exp  = 8'(int'(e) - lz);
        r.frac = v[23:1];
        r.grd  = v[0];
        r.stk  = st;
      end
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // One cycle starting at a negedge: drive, score both handshakes, advance.
  task automatic step(input logic iv, input logic [25:0] s, input logic [7:0] e,
                      input logic sg, input logic st, input logic ordy, output logic acc);
    exp_t r;
    in_valid  = iv;
    in_sum    = s;
    in_exp    = e;
    in_sign   = sg;
    in_stk    = st;
    out_ready = ordy;
    #1;
    acc = in_valid & in_ready;
    if (acc) sb.push_back(model(s, e, sg, st));
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 64'd1, 64'd0);
      end else begin
        r = sb.pop_front();
        chk("stream_result", 64'(cur_out()), 64'(r));
      end
    end
    @(negedge clk);
  endtask

  function automatic vec_t mk(input string nm, input logic [25:0] s, input logic [7:0] e,
                              input logic sg, input logic st, input logic rs,
                              input logic [7:0] re, input logic [22:0] rf,
                              input logic rg, input logic rk);
    vec_t v;
    v.nm  = nm;
    v.sum = s;
    v.exp = e;
    v.sign = sg;
    v.stk = st;
    v.res = {rs, re, rf, rg, rk};
    return v;
  endfunction

  function automatic logic [25:0] rnd_sum();
    logic [25:0] v;
    v = 26'($urandom);
    case ($urandom_range(0, 3))
      0:       return v;
      1:       return (v & 26'h1ffffff) >> $urandom_range(0, 25);
      2:       return 26'h1ffffff >> $urandom_range(0, 25);
      default: return ($urandom_range(0, 7) == 0) ? 26'd0 : (v & 26'h1ffffff);
    endcase
  endfunction

  vec_t vt[11];

  initial begin
    logic        acc;
    logic        seen;
    int          n;
    int          idx;
    exp_t        held;
    logic [25:0] bp_sum[4];
    logic [7:0]  bp_exp[4];

    vt[0]  = mk("carry",      26'h3000000, 8'd127, 1'b0, 1'b0, 1'b0, 8'd128, 23'h400000, 1'b0, 1'b0);
    vt[1]  = mk("cancel16",   26'h0000100, 8'd100, 1'b0, 1'b0, 1'b0, 8'd84,  23'h000000, 1'b0, 1'b0);
    vt[2]  = mk("cancel16b",  26'h0000180, 8'd100, 1'b0, 1'b0, 1'b0, 8'd84,  23'h400000, 1'b0, 1'b0);
    vt[3]  = mk("zero",       26'h0000000, 8'd50,  1'b1, 1'b0, 1'b0, 8'd0,   23'h000000, 1'b0, 1'b0);
    vt[4]  = mk("flush_eq",   26'h0000100, 8'd16,  1'b1, 1'b0, 1'b1, 8'd0,   23'h000000, 1'b0, 1'b0);
    vt[5]  = mk("min_norm",   26'h0000100, 8'd17,  1'b1, 1'b1, 1'b1, 8'd1,   23'h000000, 1'b0, 1'b1);
    vt[6]  = mk("to_inf",     26'h2000001, 8'd254, 1'b1, 1'b1, 1'b1, 8'd255, 23'h000000, 1'b0, 1'b0);
    vt[7]  = mk("no_shift",   26'h1000003, 8'd10,  1'b0, 1'b0, 1'b0, 8'd10,  23'h000001, 1'b1, 1'b0);
    vt[8]  = mk("carry_stk",  26'h2000003, 8'd253, 1'b0, 1'b0, 1'b0, 8'd254, 23'h000000, 1'b1, 1'b1);
    vt[9]  = mk("lz24",       26'h0000001, 8'd25,  1'b0, 1'b1, 1'b0, 8'd1,   23'h000000, 1'b0, 1'b1);
    vt[10] = mk("exp0_flush", 26'h1000000, 8'd0,   1'b1, 1'b0, 1'b1, 8'd0,   23'h000000, 1'b0, 1'b0);

    rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_exp = '0; in_sign = 1'b0; in_stk = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fields", 64'(cur_out()), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1; in_sum = vt[i].sum; in_exp = vt[i].exp;
      in_sign = vt[i].sign; in_stk = vt[i].stk; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 8) begin
        @(negedge clk);
        n++;
      end
      chk({vt[i].nm, "_latency"}, 64'(n), 64'd2);
      chk({vt[i].nm, "_sign"}, 64'(out_sign), 64'(vt[i].res.sign));
      chk({vt[i].nm, "_exp"},  64'(out_exp),  64'(vt[i].res.exp));
      chk({vt[i].nm, "_frac"}, 64'(out_frac), 64'(vt[i].res.frac));
      chk({vt[i].nm, "_grd"},  64'(out_grd),  64'(vt[i].res.grd));
      chk({vt[i].nm, "_stk"},  64'(out_stk),  64'(vt[i].res.stk));
      @(negedge clk);
    end

    // Backpressure: four pending inputs against a stalled consumer.
    bp_sum[0] = 26'h0000180; bp_exp[0] = 8'd100;
    bp_sum[1] = 26'h3000000; bp_exp[1] = 8'd127;
    bp_sum[2] = 26'h0123456; bp_exp[2] = 8'd90;
    bp_sum[3] = 26'h1ABCDEF; bp_exp[3] = 8'd200;
    idx = 0; seen = 1'b0; held = '0;
    for (int c = 0; c < 5; c++) begin
      if (out_valid && !seen) begin
        seen = 1'b1;
        held = cur_out();
      end
      step(1'b1, bp_sum[idx], bp_exp[idx], 1'b0, 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    chk("bp_accepts", 64'(idx), 64'd2);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    chk("bp_hold_stable", 64'(cur_out()), 64'(held));
    n = 0;
    while ((idx < 4 || sb.size() != 0) && n < 40) begin
      step((idx < 4) ? 1'b1 : 1'b0, bp_sum[idx % 4], bp_exp[idx % 4], 1'b0, 1'b0, 1'b1, acc);
      if (acc) idx++;
      n++;
    end
    chk("bp_drained", 64'(sb.size()), 64'd0);
    chk("bp_all_sent", 64'(idx), 64'd4);

    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 3) != 0, rnd_sum(),
           ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 30)) : 8'($urandom_range(0, 254)),
           1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0, acc);
    end
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
      n++;
    end
    chk("rand_drained", 64'(sb.size()), 64'd0);

    // Reset with both stages occupied.
    step(1'b1, 26'h1234567, 8'd150, 1'b1, 1'b1, 1'b0, acc);
    step(1'b1, 26'h2345678, 8'd150, 1'b1, 1'b1, 1'b0, acc);
    chk("mid_full_out_valid", 64'(out_valid), 64'd1);
    chk("mid_full_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0; out_ready = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_fields", 64'(cur_out()), 64'd0);
    @(negedge clk);
    chk("mid_rst_stays_empty", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
